tdc_multich_core: RTL and testbench
===================================

Name: tdc_multich_core

Overview:
- Parametrised multi-channel time-to-digital converter core that sits behind the TinyTapeout top wrapper.
- Each channel measures the start-to-stop interval as a coarse clock-cycle count plus a fine delay-line thermometer code.
- Completed measurements are tagged with their channel and pushed into a shared result FIFO.
- The wrapper drains the FIFO over a valid/ready handshake.

Parameters:
- NUM_CH, 2, number of measurement channels (1..8).
- CNT_W, 12, coarse counter width; the timeout value is 2^CNT_W-1.
- FINE_W, 8, number of thermometer taps from the external delay line.
- FIFO_DEPTH, 4, result FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  NUM_CH  asynchronous start pulses, one per channel.
- stop_i  in  NUM_CH  asynchronous stop pulses, one per channel.
- fine_i  in  NUM_CH*FINE_W  thermometer tap snapshots, one FINE_W slice per channel, stable from the stop edge onward.
- chan_en_i  in  NUM_CH  per-channel enable.
- oneshot_i  in  1  0 = continuous re-arm, 1 = single-shot.
- arm_i  in  NUM_CH  re-arm pulse per channel, used in single-shot mode.
- res_data_o  out  RW  result record {chan_id, ovf, coarse, fine}, MSB first. RW = CH_W+1+CNT_W+FNW, with CH_W = max(1,clog2(NUM_CH)) and FNW = clog2(FINE_W+1).
- res_valid_o  out  1  FIFO head is valid.
- res_ready_i  in  1  consumer accepts the head.
- fifo_cnt_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy_o  out  NUM_CH  channel is in RUN.
- drop_o  out  NUM_CH  one-cycle pulse: a start edge was ignored while the channel was in DONE or HOLD.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- On reset: all channels go to IDLE, the FIFO is empty, and all outputs are 0 (res_valid_o, fifo_cnt_o, busy_o, drop_o, res_data_o).
- Edge detection: start_i and stop_i each pass through a 2-flop synchronizer plus a registered rising-edge detector, giving start_evt and stop_evt. Both paths have identical 3-cycle latency.
- Channel FSM states: IDLE, RUN, DONE, HOLD.
- IDLE: on start_evt with chan_en=1, go to RUN with coarse=0.
- RUN: coarse increments by 1 each cycle.
  - On stop_evt, latch coarse, set fine = popcount(fine slice) (bubble-tolerant), set ovf=0, go to DONE.
  - If coarse reaches 2^CNT_W-1 without stop_evt, latch coarse=all-ones, fine=0, ovf=1, go to DONE.
  - A start_evt during RUN is ignored; the measurement is not restarted.
- Coarse value: equals the raw start-to-stop edge spacing in clk cycles. With stop_evt exactly N cycles after start_evt, coarse = N.
- Same-cycle start and stop: stop_evt in the same cycle as the start_evt that leaves IDLE is ignored.
- DONE: the channel requests a FIFO push. Arbitration is fixed priority, lowest channel index first, one push per cycle. A push is granted only when the FIFO is not full (no push-on-pop-when-full).
  - When granted: go to IDLE if oneshot_i=0, else go to HOLD.
- HOLD: on arm_i for that channel, go to IDLE.
- drop_o: a start_evt arriving in DONE or HOLD pulses drop_o for one cycle.
- Disable: chan_en=0 in any state forces IDLE next cycle. A pending DONE record is discarded, and busy_o clears.
- Result FIFO: first-word-fall-through.
  - res_valid_o = (fifo_cnt_o != 0).
  - A pop occurs when res_valid_o and res_ready_i are both 1.
  - Push and pop in the same cycle are allowed when not full; fifo_cnt_o is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - res_data_o is held stable while valid and not ready.
- Latency: a granted push makes the record visible at the FIFO head the next cycle if the FIFO was empty.
- Reset mid-measurement: all in-flight and FIFO data is lost.

Decomposition:
- Package tdc_pkg holds:
  - the chan_state_e enum (IDLE, RUN, DONE, HOLD);
  - the width functions CH_W, FNW, RW;
  - the record field offset constants.
- One sub-module, tdc_channel, instantiated NUM_CH times. It contains the synchronizers, edge detect, FSM, coarse counter and fine popcount.
- The arbiter and FIFO stay in the top of this block.

Test Plan:
- Basic timing: ch0 start, stop raw 10 cycles later, ready=1 -> one record {0,0,10,popcount(fine)}. With fine=8'b00011111 the fine field is 5.
- Timeout: CNT_W=4, ch1 start with no stop -> after 15 cycles, record {1,1,15,0}. busy_o[1] falls when the channel leaves RUN.
- Simultaneous DONE: both channels finish in the same cycle -> ch0 record pushed first, ch1 record the next cycle, fifo_cnt_o reaches 2.
- Backpressure: ready=0, 5 measurements with FIFO_DEPTH=4 -> fifo_cnt_o saturates at 4, ch0 holds in DONE, and a further start pulses drop_o[0]. Raising ready drains all 5 records in order with data stable while held.
- Single-shot: oneshot_i=1 -> second start is ignored with a drop_o pulse until arm_i[0]. After the arm, the next start measures normally.
- Abort and reset: chan_en_i[0]=0 mid-RUN -> no record, IDLE next cycle. rst asserted with 3 FIFO entries -> fifo_cnt_o=0 and res_valid_o=0 the next cycle.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and record-layout helpers for the multi-channel TDC core.
// The record is {chan_id, ovf, coarse, fine}, MSB first.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        HOLD
    } chan_state_e;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int fnw(input int fine_w);
        return $clog2(fine_w + 1);
    endfunction

    function automatic int rw(input int num_ch, input int cnt_w, input int fine_w);
        return ch_w(num_ch) + 1 + cnt_w + fnw(fine_w);
    endfunction

    // Field LSB positions inside a record; the fine field sits at bit 0.
    function automatic int coarse_lsb(input int fine_w);
        return fnw(fine_w);
    endfunction

    function automatic int ovf_bit(input int cnt_w, input int fine_w);
        return fnw(fine_w) + cnt_w;
    endfunction

    function automatic int chan_lsb(input int cnt_w, input int fine_w);
        return fnw(fine_w) + cnt_w + 1;
    endfunction

endpackage

// File: rtl/tdc_channel.sv
// One TDC measurement channel: input synchronizers, edge detection,
// state machine, coarse cycle counter and bubble-tolerant fine popcount.
module tdc_channel
    import tdc_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter int FINE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [FINE_W-1:0]        taps,
    input  logic                     en,
    input  logic                     oneshot,
    input  logic                     arm,
    input  logic                     grant,
    output logic                     req,
    output logic                     busy,
    output logic                     drop,
    output logic                     ovf,
    output logic [CNT_W-1:0]         coarse,
    output logic [fnw(FINE_W)-1:0]   fine
);

    localparam int FNW = fnw(FINE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [2:0]     start_sync;
    logic [2:0]     stop_sync;
    logic           start_evt;
    logic           stop_evt;
    logic [FNW-1:0] tap_count;
    chan_state_e    state;
    chan_state_e    state_nxt;

    // Start and stop share the same depth so the measured spacing is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_sync <= '0;
            stop_sync  <= '0;
            start_evt  <= 1'b0;
            stop_evt   <= 1'b0;
        end else begin
            start_sync <= {start_sync[1:0], start};
            stop_sync  <= {stop_sync[1:0], stop};
            start_evt  <= start_sync[1] & ~start_sync[2];
            stop_evt   <= stop_sync[1] & ~stop_sync[2];
        end
    end

    always_comb begin
        tap_count = '0;
        for (int k = 0; k < FINE_W; k++) begin
            tap_count = tap_count + FNW'(taps[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Disable overrides every other transition and drops any pending record.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_evt) state_nxt = RUN;
            RUN:     if (stop_evt || coarse == CNT_LAST) state_nxt = DONE;
            DONE:    if (grant) state_nxt = oneshot ? HOLD : IDLE;
            HOLD:    if (arm) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!en) begin
            state_nxt = IDLE;
        end
    end

    // Coarse counts from 0 on the RUN entry, so the value latched on stop is
    // already incremented by one and equals the raw edge spacing.
    always_ff @(posedge clk) begin
        if (rst) begin
            coarse <= '0;
            fine   <= '0;
            ovf    <= 1'b0;
            drop   <= 1'b0;
        end else begin
            drop <= start_evt && (state == DONE || state == HOLD);
            if (state == IDLE && state_nxt == RUN) begin
                coarse <= '0;
            end else if (state == RUN) begin
                coarse <= coarse + CNT_W'(1);
                if (stop_evt) begin
                    fine <= tap_count;
                    ovf  <= 1'b0;
                end else if (coarse == CNT_LAST) begin
                    fine <= '0;
                    ovf  <= 1'b1;
                end
            end
        end
    end

    assign req  = (state == DONE) && en;
    assign busy = (state == RUN);

endmodule

// File: rtl/tdc_multich_core.sv
// Multi-channel TDC core: NUM_CH channels feed a fixed-priority arbiter
// that pushes tagged records into a first-word-fall-through result FIFO.
module tdc_multich_core
    import tdc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 12,
    parameter int FINE_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CH-1:0]                     start_i,
    input  logic [NUM_CH-1:0]                     stop_i,
    input  logic [NUM_CH*FINE_W-1:0]              fine_i,
    input  logic [NUM_CH-1:0]                     chan_en_i,
    input  logic                                  oneshot_i,
    input  logic [NUM_CH-1:0]                     arm_i,
    output logic [rw(NUM_CH, CNT_W, FINE_W)-1:0]  res_data_o,
    output logic                                  res_valid_o,
    input  logic                                  res_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_cnt_o,
    output logic [NUM_CH-1:0]                     busy_o,
    output logic [NUM_CH-1:0]                     drop_o
);

    localparam int CH_W       = ch_w(NUM_CH);
    localparam int FNW        = fnw(FINE_W);
    localparam int RW         = rw(NUM_CH, CNT_W, FINE_W);
    localparam int COARSE_LSB = coarse_lsb(FINE_W);
    localparam int OVF_BIT    = ovf_bit(CNT_W, FINE_W);
    localparam int CHAN_LSB   = chan_lsb(CNT_W, FINE_W);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);

    logic [NUM_CH-1:0]            req;
    logic [NUM_CH-1:0]            grant;
    logic [NUM_CH-1:0]            ch_ovf;
    logic [NUM_CH-1:0][CNT_W-1:0] ch_coarse;
    logic [NUM_CH-1:0][FNW-1:0]   ch_fine;
    logic [RW-1:0]                rec [NUM_CH];
    logic [RW-1:0]                push_data;
    logic [RW-1:0]                mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic                         full;
    logic                         push;
    logic                         pop;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tdc_channel #(
            .CNT_W  (CNT_W),
            .FINE_W (FINE_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .start   (start_i[i]),
            .stop    (stop_i[i]),
            .taps    (fine_i[i*FINE_W +: FINE_W]),
            .en      (chan_en_i[i]),
            .oneshot (oneshot_i),
            .arm     (arm_i[i]),
            .grant   (grant[i]),
            .req     (req[i]),
            .busy    (busy_o[i]),
            .drop    (drop_o[i]),
            .ovf     (ch_ovf[i]),
            .coarse  (ch_coarse[i]),
            .fine    (ch_fine[i])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rec[i] = '0;
            rec[i][CHAN_LSB +: CH_W]     = CH_W'(i);
            rec[i][OVF_BIT]              = ch_ovf[i];
            rec[i][COARSE_LSB +: CNT_W]  = ch_coarse[i];
            rec[i][0 +: FNW]             = ch_fine[i];
        end
    end

    // Scanning from the top down lets the lowest requesting channel win.
    always_comb begin
        grant     = '0;
        push_data = '0;
        if (!full) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    push_data = rec[i];
                end
            end
        end
    end

    assign full        = (fifo_cnt_o == DEPTH_CNT);
    assign push        = |grant;
    assign res_valid_o = (fifo_cnt_o != '0);
    assign pop         = res_valid_o && res_ready_i;
    assign res_data_o  = res_valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_o <= fifo_cnt_o + CNT_ONE;
                2'b01:   fifo_cnt_o <= fifo_cnt_o - CNT_ONE;
                default: fifo_cnt_o <= fifo_cnt_o;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_tdc_multich_core.sv
// Scoreboard bench for tdc_multich_core: directed measurements push expected
// records into a queue that a separate monitor checks against the FIFO head.
module tb_tdc_multich_core;

    localparam int NUM_CH     = 2;
    localparam int CNT_W      = 4;
    localparam int FINE_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int RW         = 10;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        start_i = '0;
    logic [NUM_CH-1:0]        stop_i = '0;
    logic [NUM_CH*FINE_W-1:0] fine_i = '0;
    logic [NUM_CH-1:0]        chan_en_i = '1;
    logic                     oneshot_i = 1'b0;
    logic [NUM_CH-1:0]        arm_i = '0;
    logic [RW-1:0]            res_data_o;
    logic                     res_valid_o;
    logic                     res_ready_i = 1'b1;
    logic [2:0]               fifo_cnt_o;
    logic [NUM_CH-1:0]        busy_o;
    logic [NUM_CH-1:0]        drop_o;

    int            n_checks = 0;
    int            n_pass = 0;
    logic [RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    tdc_multich_core #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .FINE_W     (FINE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .fine_i      (fine_i),
        .chan_en_i   (chan_en_i),
        .oneshot_i   (oneshot_i),
        .arm_i       (arm_i),
        .res_data_o  (res_data_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .fifo_cnt_o  (fifo_cnt_o),
        .busy_o      (busy_o),
        .drop_o      (drop_o)
    );

    function automatic logic [RW-1:0] mk_rec(input int ch, input int ov, input int coarse, input int fine);
        return {ch[0], ov[0], coarse[3:0], fine[3:0]};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Raw stop edge follows the raw start edge by n cycles.
    task automatic applyStimulus(input int ch, input int n, input logic [7:0] taps);
        fine_i[ch*FINE_W +: FINE_W] = taps;
        start_i[ch] = 1'b1;
        step(n);
        start_i[ch] = 1'b0;
        stop_i[ch]  = 1'b1;
        step(2);
        stop_i[ch]  = 1'b0;
    endtask

    task automatic pulse_start(input int ch);
        start_i[ch] = 1'b1;
        step(2);
        start_i[ch] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL rec_extra: got %h, expected no record", res_data_o);
            end else begin
                if (res_data_o == exp_q[0]) n_pass++;
                else $display("[TB] FAIL rec_head: got %h, expected %h", res_data_o, exp_q[0]);
                if (res_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        step(3);
        checkOutput("rst_valid", int'(res_valid_o), 0);
        checkOutput("rst_cnt", int'(fifo_cnt_o), 0);
        checkOutput("rst_busy", int'(busy_o), 0);
        checkOutput("rst_drop", int'(drop_o), 0);
        checkOutput("rst_data", int'(res_data_o), 0);
        rst = 1'b0;
        step(2);

        $display("[TB] basic timing");
        exp_q.push_back(mk_rec(0, 0, 10, 5));
        applyStimulus(0, 10, 8'b0001_1111);
        step(3);
        checkOutput("basic_cnt_push", int'(fifo_cnt_o), 1);
        step(1);
        checkOutput("basic_cnt_drain", int'(fifo_cnt_o), 0);
        step(4);

        $display("[TB] bubbled thermometer");
        exp_q.push_back(mk_rec(1, 0, 7, 5));
        applyStimulus(1, 7, 8'b0010_1111);
        step(8);

        $display("[TB] timeout");
        exp_q.push_back(mk_rec(1, 1, 15, 0));
        fine_i[FINE_W +: FINE_W] = 8'hFF;
        pulse_start(1);
        step(16);
        checkOutput("timeout_busy", int'(busy_o[1]), 1);
        step(1);
        checkOutput("timeout_busy_fall", int'(busy_o[1]), 0);
        step(6);

        $display("[TB] simultaneous done");
        res_ready_i = 1'b0;
        exp_q.push_back(mk_rec(0, 0, 6, 2));
        exp_q.push_back(mk_rec(1, 0, 6, 7));
        fork
            applyStimulus(0, 6, 8'h03);
            applyStimulus(1, 6, 8'h7F);
        join
        step(3);
        checkOutput("simul_cnt1", int'(fifo_cnt_o), 1);
        step(1);
        checkOutput("simul_cnt2", int'(fifo_cnt_o), 2);
        res_ready_i = 1'b1;
        step(6);
        checkOutput("simul_drained", int'(fifo_cnt_o), 0);

        $display("[TB] backpressure");
        res_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] taps;
            taps = 8'((1 << (k + 1)) - 1);
            exp_q.push_back(mk_rec(0, 0, 3 + k, k + 1));
            applyStimulus(0, 3 + k, taps);
            step(2);
        end
        step(4);
        checkOutput("bp_cnt_full", int'(fifo_cnt_o), 4);
        checkOutput("bp_ch0_not_busy", int'(busy_o[0]), 0);
        pulse_start(0);
        step(2);
        checkOutput("bp_drop_pulse", int'(drop_o[0]), 1);
        step(1);
        checkOutput("bp_drop_end", int'(drop_o[0]), 0);
        res_ready_i = 1'b1;
        step(12);
        checkOutput("bp_drained", int'(fifo_cnt_o), 0);

        $display("[TB] single-shot");
        oneshot_i = 1'b1;
        exp_q.push_back(mk_rec(0, 0, 5, 4));
        applyStimulus(0, 5, 8'h0F);
        step(5);
        pulse_start(0);
        step(2);
        checkOutput("hold_drop_pulse", int'(drop_o[0]), 1);
        checkOutput("hold_not_busy", int'(busy_o[0]), 0);
        step(1);
        checkOutput("hold_drop_end", int'(drop_o[0]), 0);
        arm_i[0] = 1'b1;
        step(1);
        arm_i[0] = 1'b0;
        exp_q.push_back(mk_rec(0, 0, 9, 8));
        applyStimulus(0, 9, 8'hFF);
        step(5);
        oneshot_i = 1'b0;
        arm_i[0] = 1'b1;
        step(1);
        arm_i[0] = 1'b0;
        step(2);

        $display("[TB] abort");
        pulse_start(0);
        step(4);
        checkOutput("abort_busy", int'(busy_o[0]), 1);
        chan_en_i[0] = 1'b0;
        step(1);
        checkOutput("abort_idle", int'(busy_o[0]), 0);
        stop_i[0] = 1'b1;
        step(2);
        stop_i[0] = 1'b0;
        step(6);
        checkOutput("abort_no_rec", int'(fifo_cnt_o), 0);
        chan_en_i[0] = 1'b1;
        step(2);

        $display("[TB] reset with queued records");
        res_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk_rec(0, 0, 4 + k, 1));
            applyStimulus(0, 4 + k, 8'h01);
            step(2);
        end
        step(4);
        checkOutput("rst_mid_cnt3", int'(fifo_cnt_o), 3);
        rst = 1'b1;
        step(1);
        checkOutput("rst_mid_cnt", int'(fifo_cnt_o), 0);
        checkOutput("rst_mid_valid", int'(res_valid_o), 0);
        exp_q.delete();
        rst = 1'b0;
        res_ready_i = 1'b1;
        step(2);
        exp_q.push_back(mk_rec(1, 0, 3, 1));
        applyStimulus(1, 3, 8'h01);
        step(8);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
